// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Includes the register-match helper used by the load-use detector.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // True when an actually-read source register matches a destination register.
  function automatic logic reg_hit(
    input logic             use_v,
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] dst
  );
    return use_v & (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// Mul/div stall sequencer: stalls for MD_LAT cycles per op, then waits in DONE
// until the op has left EX so a held ex_md_start cannot retrigger it.
module pipe_hazard_ctrl_md_seq #(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_md_start,
  input  logic mem_stall,
  output logic md_stall
);
  import pipe_hazard_ctrl_pkg::*;

  localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  md_state_t        md_state_r;
  logic [CNT_W-1:0] md_cnt_r;

  // Mul/div state and remaining-cycle counter; runs regardless of memory stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state_r <= MD_IDLE;
      md_cnt_r   <= '0;
    end else begin
      case (md_state_r)
        MD_IDLE: begin
          if (ex_md_start) begin
            md_cnt_r   <= CNT_W'(MD_LAT - 1);
            md_state_r <= (MD_LAT == 1) ? MD_DONE : MD_BUSY;
          end else begin
            md_state_r <= MD_IDLE;
          end
        end
        MD_BUSY: begin
          md_cnt_r <= md_cnt_r - CNT_W'(1);
          if (md_cnt_r == CNT_W'(1)) begin
            md_state_r <= MD_DONE;
          end else begin
            md_state_r <= MD_BUSY;
          end
        end
        MD_DONE: begin
          if (!mem_stall) begin
            md_state_r <= MD_IDLE;
          end else begin
            md_state_r <= MD_DONE;
          end
        end
        default: begin
          md_state_r <= MD_IDLE;
          md_cnt_r   <= '0;
        end
      endcase
    end
  end

  assign md_stall = ((md_state_r == MD_IDLE) & ex_md_start) | (md_state_r == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: fixed-priority
// resolution of dmem wait, mul/div, taken branch and load-use hazards.
module pipe_hazard_ctrl #(
  parameter int MD_LAT      = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_dreg,
  input  logic        ex_md_start,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_bubble,
  output logic        id_ex_en,
  output logic        id_ex_bubble,
  output logic        ex_mem_en,
  output logic        ex_mem_bubble,
  output logic        mem_wb_en,
  output logic        mem_wb_bubble,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);
  import pipe_hazard_ctrl_pkg::*;

  logic              mem_stall_s;
  logic              md_stall_s;
  logic              load_use_s;
  logic              pc_en_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_err_r;
  logic [DATA_W-1:0] stall_cnt_r;

  assign mem_stall_s = mem_req & ~dmem_ready;
  assign load_use_s  = ex_mem_read & (ex_dreg != 5'd0) &
                       (reg_hit(id_use_rs, id_rs, ex_dreg) | reg_hit(id_use_rt, id_rt, ex_dreg));

  pipe_hazard_ctrl_md_seq #(
    .MD_LAT (MD_LAT)
  ) u_md_seq (
    .clk         (clk),
    .rst         (rst),
    .ex_md_start (ex_md_start),
    .mem_stall   (mem_stall_s),
    .md_stall    (md_stall_s)
  );

  // Fixed-priority hazard resolution; lower-priority hazards re-evaluate once released
  always_comb begin
    pc_en_s       = 1'b1;
    if_id_en      = 1'b1;
    if_id_bubble  = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    ex_mem_bubble = 1'b0;
    mem_wb_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (mem_stall_s) begin
      pc_en_s       = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (md_stall_s) begin
      pc_en_s       = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (ex_br_taken) begin
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if (load_use_s) begin
      pc_en_s       = 1'b0;
      if_id_en      = 1'b0;
      id_ex_bubble  = 1'b1;
    end else begin
      pc_en_s       = 1'b1;
    end
  end

  assign pc_en = pc_en_s;

  // Consecutive dmem wait counter, sticky timeout flag and stall-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r  <= '0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      if (mem_stall_s) begin
        if (wait_cnt_r != {WAIT_W{1'b1}}) begin
          wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
          wait_cnt_r <= wait_cnt_r;
        end
        if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
          mem_err_r <= 1'b1;
        end else begin
          mem_err_r <= mem_err_r;
        end
      end else begin
        wait_cnt_r <= '0;
      end
      if (!pc_en_s) begin
        stall_cnt_r <= stall_cnt_r + DATA_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;

endmodule
